fpmul_result_buffer: RTL and testbench
======================================

Name: fpmul_result_buffer

Overview:
Downstream stage of the FP multiplier wrapper. It accepts IEEE-754 single-precision products over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Each word is classified at enqueue time. The block keeps saturating NaN/Inf event counters for the result checker and testbench monitor. Words are presented to the consumer in arrival order with their class code.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 16, width of each event counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  producer has a product on in_data
in_ready  output  1  buffer can accept this cycle
in_data  input  32  FP32 product from multiplier stage
out_valid  output  1  head entry available
out_ready  input  1  consumer takes head this cycle
out_data  output  32  head FP32 word
out_class  output  3  head class: 0 ZERO, 1 DENORM, 2 NORMAL, 3 INF, 4 NAN
level  output  $clog2(DEPTH+1)  current occupancy
nan_cnt  output  CNT_W  accepted NaN words, saturating
inf_cnt  output  CNT_W  accepted Inf words, saturating
clr  input  1  synchronous clear of nan_cnt/inf_cnt only

Behaviour:
- Reset (async, rst=1): wr_ptr=rd_ptr=0, level=0, nan_cnt=inf_cnt=0, out_valid=0, in_ready=1, out_data=0, out_class=0. Storage contents are don't-care. Reset mid-transfer discards all entries. No handshake completes in a cycle where rst is high.
- Accept: in_valid & in_ready at a rising edge. The entry {class, in_data} is written at wr_ptr, and wr_ptr increments mod DEPTH.
- Pop: out_valid & out_ready at a rising edge. rd_ptr increments mod DEPTH.
- in_ready = (level != DEPTH). out_valid = (level != 0). Both are derived from registered state only, never from in_valid or out_ready.
- out_data/out_class always show the entry at rd_ptr. They must hold stable while out_valid=1 and out_ready=0.
- Latency: a word accepted into an empty buffer is visible on out_valid/out_data at the next cycle. There is no same-cycle pass-through.
- Simultaneous accept and pop: level unchanged, both pointers advance.
  - Full: in_ready=0, so only a pop is possible.
  - Empty: out_valid=0, so only an accept is possible.
- Pointers: log2(DEPTH) bits, wrap naturally. level is tracked separately to distinguish full from empty.
- Classification of in_data (e = bits 30:23, m = bits 22:0):
  - e=0, m=0: ZERO
  - e=0, m!=0: DENORM
  - e=255, m=0: INF
  - e=255, m!=0: NAN
  - otherwise: NORMAL
  - Sign is ignored.
- Counters: nan_cnt increments on each accepted NAN word and inf_cnt on each accepted INF word. Both saturate at 2^CNT_W-1 and do not wrap.
- clr=1: both counters become 0 next cycle. clr has priority over a same-cycle accepted NAN/INF, which is not counted.
- Producer rules: the producer must hold in_data stable while in_valid=1 and not accepted. The block does not check this.
- in_data is sampled only on accept. in_valid with in_ready=0 has no effect.

Test Plan:
- Reset then push 0x40400000 (3.0) → next cycle out_valid=1, out_data=0x40400000, out_class=2, level=1; pop with out_ready=1 → level=0, out_valid=0.
- Push 0x00000000, 0x80000001, 0x7F800000, 0x7FC00000 with out_ready=0 → classes drain in order 0,1,3,4; level reaches 4, in_ready=0; nan_cnt=1, inf_cnt=1.
- Full (DEPTH=4) with in_valid=1, in_data=0x3F800000 held 3 cycles → level stays 4, no overwrite; after one pop, the word is accepted on the next edge and appears 4th in drain order.
- Continuous in_valid=1, out_ready=1 with 20 distinct words → steady throughput of 1 word/cycle after a 1-cycle initial latency, level stays 1, pointers wrap, output order is exact.
- CNT_W=2, push 5 NaN words (0xFFC00001) → nan_cnt saturates at 3; clr pulsed in the same cycle as a 0x7F800000 accept → inf_cnt=0.
- Assert rst asynchronously mid-cycle with level=3 → immediately out_valid=0, level=0, counters 0, in_ready=1; the first push after deassert comes out alone.

Source files
------------

// File: rtl/fpmul_result_buffer.sv
// Result buffer for the FP32 multiplier: a DEPTH-entry FIFO that tags each word with its class
// and keeps saturating NaN/Inf counters. All outputs come straight from flops.
module fpmul_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [2:0]                 out_class,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           nan_cnt,
  output logic [CNT_W-1:0]           inf_cnt,
  input  logic                       clr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [2:0] CLS_ZERO   = 3'd0;
  localparam logic [2:0] CLS_DENORM = 3'd1;
  localparam logic [2:0] CLS_NORMAL = 3'd2;
  localparam logic [2:0] CLS_INF    = 3'd3;
  localparam logic [2:0] CLS_NAN    = 3'd4;

  function automatic logic [2:0] classify(input logic [31:0] w);
    logic [7:0]  e;
    logic [22:0] m;
    e = w[30:23];
    m = w[22:0];
    if (e == 8'd0) begin
      classify = (m == 23'd0) ? CLS_ZERO : CLS_DENORM;
    end else if (e == 8'hFF) begin
      classify = (m == 23'd0) ? CLS_INF : CLS_NAN;
    end else begin
      classify = CLS_NORMAL;
    end
  endfunction

  logic [34:0]      mem_q [DEPTH];
  logic [34:0]      mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d, inf_cnt_q, inf_cnt_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [2:0]       out_class_q, out_class_d;
  logic             acc_s, pop_s;
  logic [2:0]       in_cls_s;

  // Next-state for pointers, occupancy, storage, head register and counters.
  always_comb begin
    in_cls_s  = classify(in_data);
    acc_s     = in_valid & in_ready_q;
    pop_s     = out_valid_q & out_ready;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    nan_cnt_d = nan_cnt_q;
    inf_cnt_d = inf_cnt_q;
    if (acc_s) begin
      mem_d[wr_ptr_q] = {in_cls_s, in_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({acc_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // clr wins over a same-cycle NaN/Inf accept.
    if (clr) begin
      nan_cnt_d = {CNT_W{1'b0}};
      inf_cnt_d = {CNT_W{1'b0}};
    end else if (acc_s && (in_cls_s == CLS_NAN) && (nan_cnt_q != CNT_MAX)) begin
      nan_cnt_d = nan_cnt_q + CNT_W'(1);
    end else if (acc_s && (in_cls_s == CLS_INF) && (inf_cnt_q != CNT_MAX)) begin
      inf_cnt_d = inf_cnt_q + CNT_W'(1);
    end else begin
      nan_cnt_d = nan_cnt_q;
      inf_cnt_d = inf_cnt_q;
    end
    in_ready_d  = (level_d != FULL_LVL);
    out_valid_d = (level_d != LW'(0));
    {out_class_d, out_data_d} = mem_d[rd_ptr_d];
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      level_q     <= {LW{1'b0}};
      nan_cnt_q   <= {CNT_W{1'b0}};
      inf_cnt_q   <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_class_q <= 3'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      nan_cnt_q   <= nan_cnt_d;
      inf_cnt_q   <= inf_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_class_q <= out_class_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_class = out_class_q;
  assign level     = level_q;
  assign nan_cnt   = nan_cnt_q;
  assign inf_cnt   = inf_cnt_q;

endmodule

// File: tb/tb_fpmul_result_buffer.sv
// Randomised bench for fpmul_result_buffer: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations. Two instances differ only in CNT_W.
module tb_fpmul_result_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, clr = 1'b0;
  logic [31:0] in_data = 32'd0;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_data, b_out_data;
  logic [2:0]  a_out_class, b_out_class;
  logic [2:0]  a_level, b_level;
  logic [15:0] a_nan, a_inf;
  logic [1:0]  b_nan, b_inf;

  fpmul_result_buffer #(.DEPTH(DEPTH), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_class(a_out_class), .level(a_level), .nan_cnt(a_nan), .inf_cnt(a_inf), .clr(clr));

  fpmul_result_buffer #(.DEPTH(DEPTH), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_class(b_out_class), .level(b_level), .nan_cnt(b_nan), .inf_cnt(b_inf), .clr(clr));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];
  logic [31:0] popped[$];
  int nan_a = 0, inf_a = 0, nan_b = 0, inf_b = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] cls_of(input logic [31:0] w);
    logic [7:0]  e;
    logic [22:0] m;
    e = w[30:23];
    m = w[22:0];
    if (e == 8'd0)       return (m == 23'd0) ? 3'd0 : 3'd1;
    else if (e == 8'hFF) return (m == 23'd0) ? 3'd3 : 3'd4;
    else                 return 3'd2;
  endfunction

  function automatic logic [31:0] rand_word();
    logic        s;
    logic [22:0] m;
    logic [7:0]  e;
    s = 1'($urandom_range(1));
    m = 23'($urandom_range(1, 23'h7FFFFF));
    e = 8'($urandom_range(1, 254));
    case ($urandom_range(4))
      0:       return {s, 31'd0};
      1:       return {s, 8'd0, m};
      2:       return {s, e, m};
      3:       return {s, 8'hFF, 23'd0};
      default: return {s, 8'hFF, m};
    endcase
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    q.delete();
    nan_a = 0; inf_a = 0; nan_b = 0; inf_b = 0;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, settle past negedge.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c);
    bit acc, pop;
    logic [2:0] k;
    in_valid = v; in_data = d; out_ready = r; clr = c;
    acc = v && !rst && (q.size() < DEPTH);
    pop = r && !rst && (q.size() > 0);
    k = cls_of(d);
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (pop) popped.push_back(q.pop_front());
      if (acc) q.push_back(d);
      if (c) begin
        nan_a = 0; inf_a = 0; nan_b = 0; inf_b = 0;
      end else if (acc && k == 3'd4) begin
        nan_a = sat_inc(nan_a, 65535); nan_b = sat_inc(nan_b, 3);
      end else if (acc && k == 3'd3) begin
        inf_a = sat_inc(inf_a, 65535); inf_b = sat_inc(inf_b, 3);
      end
    end
    @(negedge clk);
    #1;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_out_valid", 32'(a_out_valid), 32'(q.size() != 0));
      check("a_in_ready",  32'(a_in_ready),  32'(q.size() != DEPTH));
      check("a_level",     32'(a_level),     32'(q.size()));
      check("a_nan_cnt",   32'(a_nan),       32'(nan_a));
      check("a_inf_cnt",   32'(a_inf),       32'(inf_a));
      check("b_level",     32'(b_level),     32'(q.size()));
      check("b_nan_cnt",   32'(b_nan),       32'(nan_b));
      check("b_inf_cnt",   32'(b_inf),       32'(inf_b));
      if (q.size() != 0) begin
        check("a_out_data",  a_out_data,        q[0]);
        check("a_out_class", 32'(a_out_class),  32'(cls_of(q[0])));
        check("b_out_data",  b_out_data,        q[0]);
        check("b_out_class", 32'(b_out_class),  32'(cls_of(q[0])));
      end
    end
  end

  initial begin
    logic [31:0] w;
    int base;
    #12;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_in_ready",  32'(a_in_ready),  32'd1);
    check("rst_out_data",  a_out_data,       32'd0);
    check("rst_out_class", 32'(a_out_class), 32'd0);
    check("rst_level",     32'(a_level),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_en = 1'b1;

    // Single word through an empty buffer.
    step(1'b1, 32'h40400000, 1'b0, 1'b0);
    check("t1_valid", 32'(a_out_valid), 32'd1);
    check("t1_data",  a_out_data,       32'h40400000);
    check("t1_class", 32'(a_out_class), 32'd2);
    check("t1_level", 32'(a_level),     32'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check("t1_pop_level", 32'(a_level),     32'd0);
    check("t1_pop_valid", 32'(a_out_valid), 32'd0);

    // Fill with one of each special class.
    popped.delete();
    step(1'b1, 32'h00000000, 1'b0, 1'b0);
    step(1'b1, 32'h80000001, 1'b0, 1'b0);
    step(1'b1, 32'h7F800000, 1'b0, 1'b0);
    step(1'b1, 32'h7FC00000, 1'b0, 1'b0);
    check("t2_level",    32'(a_level),    32'd4);
    check("t2_in_ready", 32'(a_in_ready), 32'd0);
    check("t2_nan",      32'(a_nan),      32'd1);
    check("t2_inf",      32'(a_inf),      32'd1);

    // Offer a word while full, then pop once; it must land behind the survivors.
    repeat (3) step(1'b1, 32'h3F800000, 1'b0, 1'b0);
    check("t3_level_full", 32'(a_level), 32'd4);
    check("t3_head_kept",  a_out_data,   32'h00000000);
    step(1'b1, 32'h3F800000, 1'b1, 1'b0);
    step(1'b1, 32'h3F800000, 1'b0, 1'b0);
    check("t3_refilled", 32'(a_level), 32'd4);
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);
    check("t3_drained", 32'(popped.size()), 32'd5);
    if (popped.size() == 5) begin
      check("t3_order0", 32'(cls_of(popped[0])), 32'd0);
      check("t3_order1", 32'(cls_of(popped[1])), 32'd1);
      check("t3_order2", 32'(cls_of(popped[2])), 32'd3);
      check("t3_order3", 32'(cls_of(popped[3])), 32'd4);
      check("t3_order4", popped[4], 32'h3F800000);
    end

    // Streaming: one word per cycle, level pinned at 1.
    popped.delete();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h3F000000 + 32'(i), 1'b1, 1'b0);
      check("t4_level", 32'(a_level), 32'd1);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check("t4_count", 32'(popped.size()), 32'd20);
    for (int i = 0; i < 20 && i < popped.size(); i++)
      check("t4_order", popped[i], 32'h3F000000 + 32'(i));

    // Counter saturation on the narrow instance, then clr against an Inf accept.
    repeat (5) step(1'b1, 32'hFFC00001, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check("t5_nan_sat_b", 32'(b_nan), 32'd3);
    check("t5_nan_a",     32'(a_nan), 32'd6);
    step(1'b1, 32'h7F800000, 1'b1, 1'b0);
    step(1'b1, 32'h7F800000, 1'b1, 1'b1);
    check("t5_inf_clr_a", 32'(a_inf), 32'd0);
    check("t5_inf_clr_b", 32'(b_inf), 32'd0);
    check("t5_nan_clr_a", 32'(a_nan), 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset with three entries held.
    step(1'b1, 32'h11111111, 1'b0, 1'b0);
    step(1'b1, 32'h7F800000, 1'b0, 1'b0);
    step(1'b1, 32'h7FC00000, 1'b0, 1'b0);
    check("t6_level3", 32'(a_level), 32'd3);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("t6_valid", 32'(a_out_valid), 32'd0);
    check("t6_level", 32'(a_level),     32'd0);
    check("t6_nan",   32'(a_nan),       32'd0);
    check("t6_inf",   32'(a_inf),       32'd0);
    check("t6_ready", 32'(a_in_ready),  32'd1);
    @(negedge clk);
    #1;
    step(1'b1, 32'h22222222, 1'b1, 1'b0);
    rst = 1'b0;
    popped.delete();
    step(1'b1, 32'h40A00000, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check("t6_alone_cnt",  32'(popped.size()), 32'd1);
    if (popped.size() == 1) check("t6_alone_data", popped[0], 32'h40A00000);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      w = rand_word();
      step(1'($urandom_range(99) < 60), w, 1'($urandom_range(99) < 55),
           1'($urandom_range(99) < 3));
    end
    base = checks;
    repeat (DEPTH + 1) step(1'b0, 32'd0, 1'b1, 1'b0);
    check("final_empty", 32'(a_level), 32'd0);
    check("random_ran", 32'(base > 1000), 32'd1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
